led_trig_stamp: RTL
===================

Name: led_trig_stamp

Overview:
- Downstream consumer of the LED controller outputs (TRG_FLAG, LEDBAR) inside sde_trigger.
- Timestamps each LED firing relative to the last 1PPS and measures the actual LEDBAR-low pulse width.
- Queues one record per firing in a small first-word-fall-through (FWFT) FIFO for the slow-control readout path.
- Counts firings that were missed because the FSM was busy, and firings dropped because the FIFO was full.

Parameters:
- FIFO_DEPTH, 8, record FIFO depth; power of 2, range 2..64.
- CYC_WIDTH, 27, width of the cycles-since-PPS counter (2^27 > 120e6).
- WID_WIDTH, 16, width of the measured pulse-width field.
- LOW_TIMEOUT, 4, cycles to wait for LEDBAR low after a TRG_FLAG rise.

Ports:
- CLK120  in  1  120 MHz clock.
- RESET  in  1  asynchronous, active-high reset.
- ONE_PPS  in  1  raw asynchronous 1PPS; synchronised internally.
- TRG_FLAG  in  1  LED trigger flag from the LED controller.
- LEDBAR  in  1  active-low LED drive from the LED controller.
- ENABLE  in  1  stamping enable (slow control).
- CLEAR  in  1  synchronous flush of FIFO, counters and FSM.
- RD_EN  in  1  pop head record.
- DOUT_TIME  out  32  {PPS_SEQ[4:0], CYC[26:0]} of the head record.
- DOUT_WIDTH  out  16  measured width of the head record.
- EMPTY  out  1  FIFO empty.
- COUNT  out  7  records held in the FIFO.
- MISSED  out  8  TRG_FLAG rises ignored while FSM busy; saturating.
- OVERFLOW  out  8  records dropped on FIFO full; saturating.

Behaviour:
- Reset and CLEAR: FIFO flushed (EMPTY=1, COUNT=0), MISSED=0, OVERFLOW=0, DOUT_*=0, CYC=0, PPS_SEQ=0, FSM=IDLE.
- RESET asserted mid-measurement: the partial record is discarded and never pushed.
- PPS path:
  - ONE_PPS passes through synchronizer_1bit and then rising-edge detection.
  - On the edge-detect cycle: CYC<=0 and PPS_SEQ<=PPS_SEQ+1 (5-bit, wraps 31->0).
  - Otherwise CYC increments by 1 per clock and saturates at 2^27-1 if PPS is lost.
- TRG_FLAG rise = TRG_FLAG==1 while the previous-cycle TRG_FLAG==0 (sampled registered).
- FSM states:
  - IDLE: on a TRG_FLAG rise with ENABLE=1, latch T={PPS_SEQ,CYC} of that cycle, clear W and the timeout counter, go to WAIT_LOW. ENABLE=0 means the rise is ignored and MISSED is not counted.
  - WAIT_LOW: if LEDBAR==0, set W=1 and go to MEASURE. Otherwise increment the timeout counter; when it reaches LOW_TIMEOUT, go to PUSH with W=0.
  - MEASURE: while LEDBAR==0, W<=W+1, saturating at 0xFFFF. When LEDBAR==1, go to PUSH.
  - PUSH: write {T,W} into the FIFO for one cycle, then return to IDLE.
- Any TRG_FLAG rise seen outside IDLE increments MISSED (saturates at 255).
- Nominal latency: the record is visible at the FIFO head (EMPTY deasserted) 2 cycles after LEDBAR returns high (1 cycle to PUSH, 1 cycle for the write).
- FIFO rules:
  - FWFT: DOUT_* is valid whenever EMPTY=0.
  - RD_EN=1 pops the head; the next record (or EMPTY=1) appears on the following cycle.
  - RD_EN while EMPTY: ignored, no state change.
  - Push while full, no pop in the same cycle: record dropped, OVERFLOW increments (saturates at 255).
  - Push and pop in the same cycle while full: both take effect, COUNT stays at FIFO_DEPTH, nothing dropped.
  - Push and pop in the same cycle while empty: the push is accepted and the pop ignored.
- A PPS edge during a measurement does not affect T, which is already latched.
- Clearing ENABLE mid-measurement lets the current record complete normally.

Decomposition:
- Shared header sde_trigger_defs.vh gains:
  - LED_STAMP_CYC_WIDTH (27).
  - LED_STAMP_SEQ_WIDTH (5).
  - LED_STAMP_WID_WIDTH (16).
  - The FSM state encodings (IDLE, WAIT_LOW, MEASURE, PUSH).
  - The DOUT_TIME field shift/mask macros.
- Sub-module led_stamp_fifo:
  - Parameterised synchronous FWFT FIFO, 48-bit wide.
  - Provides push, pop, flush, full, empty and count.
- Reuses the existing synchronizer_1bit.

Test Plan:
- PPS, then TRG_FLAG rise 1000 cycles later, then LEDBAR low for 50 cycles -> one record with CYC=1000, PPS_SEQ=1, W=50. EMPTY falls 2 cycles after LEDBAR rises.
- TRG_FLAG rise with LEDBAR held high -> after 4 cycles a record with W=0 is pushed, and MISSED stays 0.
- Nine firings with no reads, FIFO_DEPTH=8 -> COUNT=8, OVERFLOW=1. Eight pops return records in order, then EMPTY=1. A further RD_EN leaves everything unchanged.
- FIFO full, push and RD_EN asserted on the same cycle -> COUNT stays 8, OVERFLOW unchanged, the head advances.
- Second TRG_FLAG rise during MEASURE -> MISSED=1 and only one record is pushed. LEDBAR held low for 70000 cycles -> W=0xFFFF.
- No PPS for 2^27+10 cycles -> CYC holds at 0x7FFFFFF. 32 PPS edges -> PPS_SEQ wraps to 0. RESET asserted mid-MEASURE -> no record, all outputs return to zero.

Source files
------------

// File: rtl/led_trig_stamp_pkg.sv
// Shared definitions for the LED trigger time-stamper.
// Contents: field widths, DOUT_TIME field shift/mask, FSM state encoding
// and the helper that packs {PPS_SEQ, CYC} into the 32-bit time word.
package led_trig_stamp_pkg;

    localparam int LED_STAMP_CYC_WIDTH  = 27;
    localparam int LED_STAMP_SEQ_WIDTH  = 5;
    localparam int LED_STAMP_WID_WIDTH  = 16;
    localparam int LED_STAMP_TIME_WIDTH = LED_STAMP_SEQ_WIDTH + LED_STAMP_CYC_WIDTH;

    // DOUT_TIME layout: PPS_SEQ in [31:27], CYC in [26:0].
    localparam int          LED_STAMP_SEQ_SHIFT = 27;
    localparam logic [31:0] LED_STAMP_SEQ_MASK  = 32'hF800_0000;
    localparam logic [31:0] LED_STAMP_CYC_MASK  = 32'h07FF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_LOW = 2'd1,
        ST_MEASURE  = 2'd2,
        ST_PUSH     = 2'd3
    } stamp_state_e;

    // Pack a sequence number and a (zero-extended) cycle count into the time word.
    function automatic logic [31:0] pack_time(input logic [LED_STAMP_SEQ_WIDTH-1:0] seq,
                                              input logic [LED_STAMP_CYC_WIDTH-1:0] cyc);
        logic [31:0] word;
        word = (32'(seq) << LED_STAMP_SEQ_SHIFT) & LED_STAMP_SEQ_MASK;
        word = word | (32'(cyc) & LED_STAMP_CYC_MASK);
        return word;
    endfunction

endpackage

// File: rtl/led_stamp_fifo.sv
// Synchronous first-word-fall-through FIFO for time-stamp records.
// The head word is held in a register, so DOUT is valid whenever EMPTY=0
// and reads back as zero while empty.
// Ports: CLK, RESET (async, active-high), FLUSH (sync clear), PUSH/DIN write,
//        POP read-advance, DOUT head word, FULL, EMPTY, COUNT (records held).
import led_trig_stamp_pkg::*;

module led_stamp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             FULL,
    output logic             EMPTY,
    output logic [6:0]       COUNT
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [6:0]       count_r;
    logic             empty_r;
    logic [WIDTH-1:0] head_r;

    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [6:0]       count_nxt_s;
    logic [WIDTH-1:0] head_nxt_s;

    // Next-state computation for pointers, occupancy and the registered head.
    always_comb begin
        full_s       = (count_r == 7'(DEPTH));
        pop_ok_s     = POP & ~empty_r;
        // A full FIFO still accepts a write when the head is popped in the same cycle.
        push_ok_s    = PUSH & (~full_s | pop_ok_s);
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;

        if (push_ok_s) begin
            wr_ptr_nxt_s = AW'(wr_ptr_r + AW'(1));
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_ok_s) begin
            rd_ptr_nxt_s = AW'(rd_ptr_r + AW'(1));
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + 7'd1;
            2'b01:   count_nxt_s = count_r - 7'd1;
            default: count_nxt_s = count_r;
        endcase

        // The new head may be the word being written this very cycle.
        if (count_nxt_s == 7'd0) begin
            head_nxt_s = '0;
        end else if (push_ok_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = DIN;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Record storage; contents need no reset because the head is tracked separately.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= DIN;
        end
    end

    // Pointer, occupancy and head-word registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 7'd0;
            empty_r  <= 1'b1;
            head_r   <= '0;
        end else if (FLUSH) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 7'd0;
            empty_r  <= 1'b1;
            head_r   <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == 7'd0);
            head_r   <= head_nxt_s;
        end
    end

    assign DOUT  = head_r;
    assign FULL  = full_s;
    assign EMPTY = empty_r;
    assign COUNT = count_r;

endmodule

// File: rtl/synchronizer_1bit.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: CLK clock, RESET async active-high reset, D async input, Q synchronised output.
module synchronizer_1bit (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic Q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= D;
            sync_r <= meta_r;
        end
    end

    assign Q = sync_r;

endmodule

// File: rtl/led_trig_stamp.sv
// Time-stamps each LED firing relative to the last 1PPS, measures the
// LEDBAR-low pulse width and queues one {time, width} record per firing.
// Ports: CLK120, RESET (async, active-high), ONE_PPS (async), TRG_FLAG, LEDBAR
//        (active-low), ENABLE, CLEAR (sync flush), RD_EN (pop), DOUT_TIME,
//        DOUT_WIDTH, EMPTY, COUNT, MISSED, OVERFLOW (saturating counters).
import led_trig_stamp_pkg::*;

module led_trig_stamp #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CYC_WIDTH   = 27,
    parameter int WID_WIDTH   = 16,
    parameter int LOW_TIMEOUT = 4
) (
    input  logic                 CLK120,
    input  logic                 RESET,
    input  logic                 ONE_PPS,
    input  logic                 TRG_FLAG,
    input  logic                 LEDBAR,
    input  logic                 ENABLE,
    input  logic                 CLEAR,
    input  logic                 RD_EN,
    output logic [31:0]          DOUT_TIME,
    output logic [WID_WIDTH-1:0] DOUT_WIDTH,
    output logic                 EMPTY,
    output logic [6:0]           COUNT,
    output logic [7:0]           MISSED,
    output logic [7:0]           OVERFLOW
);

    localparam int                   TO_W    = $clog2(LOW_TIMEOUT + 1);
    localparam int                   REC_W   = 32 + WID_WIDTH;
    localparam logic [CYC_WIDTH-1:0] CYC_MAX = {CYC_WIDTH{1'b1}};
    localparam logic [WID_WIDTH-1:0] WID_MAX = {WID_WIDTH{1'b1}};

    logic                 pps_sync_s;
    logic                 pps_prev_r;
    logic                 pps_rise_s;
    logic [CYC_WIDTH-1:0] cyc_r;
    logic [4:0]           seq_r;
    logic                 trg_prev_r;
    logic                 trg_rise_s;
    logic [31:0]          stamp_s;

    stamp_state_e         state_r;
    stamp_state_e         state_nxt_s;
    logic [31:0]          t_r;
    logic [31:0]          t_nxt_s;
    logic [WID_WIDTH-1:0] w_r;
    logic [WID_WIDTH-1:0] w_nxt_s;
    logic [TO_W-1:0]      tcnt_r;
    logic [TO_W-1:0]      tcnt_nxt_s;
    logic                 push_s;

    logic [7:0]           missed_r;
    logic [7:0]           overflow_r;
    logic                 fifo_full_s;
    logic [REC_W-1:0]     fifo_dout_s;

    synchronizer_1bit u_pps_sync (
        .CLK   (CLK120),
        .RESET (RESET),
        .D     (ONE_PPS),
        .Q     (pps_sync_s)
    );

    assign pps_rise_s = pps_sync_s & ~pps_prev_r;
    assign trg_rise_s = TRG_FLAG & ~trg_prev_r;
    assign stamp_s    = pack_time(seq_r, LED_STAMP_CYC_WIDTH'(cyc_r));

    // Edge-detect history for the synchronised PPS and for TRG_FLAG.
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            pps_prev_r <= 1'b0;
            trg_prev_r <= 1'b0;
        end else begin
            pps_prev_r <= pps_sync_s;
            trg_prev_r <= TRG_FLAG;
        end
    end

    // Cycles-since-PPS counter (saturating when PPS is lost) and PPS sequence number.
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            cyc_r <= '0;
            seq_r <= 5'd0;
        end else if (CLEAR) begin
            cyc_r <= '0;
            seq_r <= 5'd0;
        end else if (pps_rise_s) begin
            cyc_r <= '0;
            seq_r <= seq_r + 5'd1;
        end else if (cyc_r != CYC_MAX) begin
            cyc_r <= cyc_r + CYC_WIDTH'(1);
        end
    end

    // Stamping FSM: next state, latched time, width and timeout bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        t_nxt_s     = t_r;
        w_nxt_s     = w_r;
        tcnt_nxt_s  = tcnt_r;
        push_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (trg_rise_s && ENABLE) begin
                    t_nxt_s     = stamp_s;
                    w_nxt_s     = '0;
                    tcnt_nxt_s  = '0;
                    state_nxt_s = ST_WAIT_LOW;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!LEDBAR) begin
                    w_nxt_s     = WID_WIDTH'(1);
                    state_nxt_s = ST_MEASURE;
                end else if (tcnt_r == TO_W'(LOW_TIMEOUT - 1)) begin
                    // Counter reaches LOW_TIMEOUT on this cycle: give up with W=0.
                    tcnt_nxt_s  = TO_W'(LOW_TIMEOUT);
                    w_nxt_s     = '0;
                    state_nxt_s = ST_PUSH;
                end else begin
                    tcnt_nxt_s  = tcnt_r + TO_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!LEDBAR) begin
                    if (w_r != WID_MAX) begin
                        w_nxt_s = w_r + WID_WIDTH'(1);
                    end else begin
                        w_nxt_s = w_r;
                    end
                end else begin
                    state_nxt_s = ST_PUSH;
                end
            end
            ST_PUSH: begin
                push_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and record-in-progress registers.
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            t_r     <= 32'd0;
            w_r     <= '0;
            tcnt_r  <= '0;
        end else if (CLEAR) begin
            state_r <= ST_IDLE;
            t_r     <= 32'd0;
            w_r     <= '0;
            tcnt_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            t_r     <= t_nxt_s;
            w_r     <= w_nxt_s;
            tcnt_r  <= tcnt_nxt_s;
        end
    end

    // Saturating counters for ignored triggers and dropped records.
    always_ff @(posedge CLK120 or posedge RESET) begin
        if (RESET) begin
            missed_r   <= 8'd0;
            overflow_r <= 8'd0;
        end else if (CLEAR) begin
            missed_r   <= 8'd0;
            overflow_r <= 8'd0;
        end else begin
            if (trg_rise_s && (state_r != ST_IDLE) && (missed_r != 8'hFF)) begin
                missed_r <= missed_r + 8'd1;
            end
            // A full FIFO is never empty, so RD_EN here is always a real pop.
            if (push_s && fifo_full_s && !RD_EN && (overflow_r != 8'hFF)) begin
                overflow_r <= overflow_r + 8'd1;
            end
        end
    end

    led_stamp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .CLK   (CLK120),
        .RESET (RESET),
        .FLUSH (CLEAR),
        .PUSH  (push_s),
        .POP   (RD_EN),
        .DIN   ({t_r, w_r}),
        .DOUT  (fifo_dout_s),
        .FULL  (fifo_full_s),
        .EMPTY (EMPTY),
        .COUNT (COUNT)
    );

    assign DOUT_TIME  = fifo_dout_s[REC_W-1:WID_WIDTH];
    assign DOUT_WIDTH = fifo_dout_s[WID_WIDTH-1:0];
    assign MISSED     = missed_r;
    assign OVERFLOW   = overflow_r;

endmodule
